// File: rtl/i2c_target.sv
// I2C target engine: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte RX/TX.
// Define I2C_TARGET_GENCALL_EN to also answer the general-call write address (8'h00).
module i2c_target #(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         FILTER_LEN  = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oe,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_tx_req,
   input  logic [7:0] i_tx_data,
   output logic       o_busy,
   output logic       o_rw
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
   } state_t;

   localparam logic [2:0] FLT_MAX = 3'(FILTER_LEN - 1);

   state_t     state, state_nxt;
   logic [1:0] scl_sync, sda_sync;
   logic [2:0] scl_cnt, sda_cnt;
   logic       scl_f, sda_f, scl_d, sda_d;
   logic       scl_rise, scl_fall, sda_rise, sda_fall;
   logic       start_det, stop_det;

   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [7:0] shift_in;
   logic       byte_done, byte_done_nxt;
   logic       sda_oe_nxt, busy_nxt, rw_nxt, rx_valid_nxt, tx_req_nxt;
   logic [7:0] rx_data_nxt;
   logic       addr_hit, gen_call;

   // A level change is accepted only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_cnt  <= '0;
         sda_cnt  <= '0;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], i_scl};
         sda_sync <= {sda_sync[0], i_sda};
         if (scl_sync[1] != scl_f) begin
            if (scl_cnt == FLT_MAX) begin
               scl_f   <= scl_sync[1];
               scl_cnt <= '0;
            end else begin
               scl_cnt <= scl_cnt + 3'd1;
            end
         end else begin
            scl_cnt <= '0;
         end
         if (sda_sync[1] != sda_f) begin
            if (sda_cnt == FLT_MAX) begin
               sda_f   <= sda_sync[1];
               sda_cnt <= '0;
            end else begin
               sda_cnt <= sda_cnt + 3'd1;
            end
         end else begin
            sda_cnt <= '0;
         end
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   end

   assign scl_rise  = scl_f & ~scl_d;
   assign scl_fall  = ~scl_f & scl_d;
   assign sda_rise  = sda_f & ~sda_d;
   assign sda_fall  = ~sda_f & sda_d;
   assign start_det = sda_fall & scl_f;
   assign stop_det  = sda_rise & scl_f;

   assign shift_in = {shreg[6:0], sda_f};
`ifdef I2C_TARGET_GENCALL_EN
   assign gen_call = (shift_in == 8'h00);
`else
   assign gen_call = 1'b0;
`endif
   assign addr_hit = (shift_in[7:1] == TARGET_ADDR) || gen_call;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte_done  <= 1'b0;
         o_sda_oe   <= 1'b0;
         o_busy     <= 1'b0;
         o_rw       <= 1'b0;
         o_rx_data  <= '0;
         o_rx_valid <= 1'b0;
         o_tx_req   <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shreg      <= shreg_nxt;
         byte_done  <= byte_done_nxt;
         o_sda_oe   <= sda_oe_nxt;
         o_busy     <= busy_nxt;
         o_rw       <= rw_nxt;
         o_rx_data  <= rx_data_nxt;
         o_rx_valid <= rx_valid_nxt;
         o_tx_req   <= tx_req_nxt;
      end
   end

   // START/STOP outrank any SCL edge seen in the same cycle.
   always_comb begin
      state_nxt = state;
      if (stop_det) begin
         state_nxt = IDLE;
      end else if (start_det) begin
         state_nxt = ADDR;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise && bit_cnt == 3'd7 && !addr_hit) state_nxt = WAIT_STOP;
               else if (scl_fall && byte_done)              state_nxt = ADDR_ACK;
            end
            ADDR_ACK: if (scl_fall) state_nxt = o_rw ? TX : RX;
            RX:       if (scl_fall && byte_done) state_nxt = RX_ACK;
            RX_ACK:   if (scl_fall) state_nxt = RX;
            TX:       if (scl_fall && bit_cnt == 3'd0) state_nxt = TX_ACK;
            TX_ACK: begin
               if (scl_rise && sda_f)            state_nxt = WAIT_STOP;
               else if (scl_fall && byte_done)   state_nxt = TX;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // In TX, bit_cnt counts bits already put on the bus; the wrap to 0 marks all eight driven.
   always_comb begin
      bit_cnt_nxt   = bit_cnt;
      shreg_nxt     = shreg;
      byte_done_nxt = byte_done;
      sda_oe_nxt    = o_sda_oe;
      busy_nxt      = o_busy;
      rw_nxt        = o_rw;
      rx_data_nxt   = o_rx_data;
      rx_valid_nxt  = 1'b0;
      tx_req_nxt    = 1'b0;
      if (stop_det) begin
         bit_cnt_nxt   = '0;
         byte_done_nxt = 1'b0;
         sda_oe_nxt    = 1'b0;
         busy_nxt      = 1'b0;
      end else if (start_det) begin
         bit_cnt_nxt   = '0;
         byte_done_nxt = 1'b0;
         sda_oe_nxt    = 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise) begin
                  shreg_nxt   = shift_in;
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rw_nxt = shift_in[0];
                     if (addr_hit) byte_done_nxt = 1'b1;
                     else          busy_nxt      = 1'b0;
                  end
               end else if (scl_fall && byte_done) begin
                  sda_oe_nxt    = 1'b1;
                  busy_nxt      = 1'b1;
                  byte_done_nxt = 1'b0;
               end
            end
            ADDR_ACK: begin
               if (scl_rise && o_rw) tx_req_nxt = 1'b1;
               if (scl_fall) begin
                  if (o_rw) begin
                     shreg_nxt   = i_tx_data;
                     sda_oe_nxt  = ~i_tx_data[7];
                     bit_cnt_nxt = 3'd1;
                  end else begin
                     sda_oe_nxt  = 1'b0;
                     bit_cnt_nxt = '0;
                  end
               end
            end
            RX: begin
               if (scl_rise) begin
                  shreg_nxt   = shift_in;
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     rx_data_nxt   = shift_in;
                     rx_valid_nxt  = 1'b1;
                     byte_done_nxt = 1'b1;
                  end
               end else if (scl_fall && byte_done) begin
                  sda_oe_nxt    = 1'b1;
                  byte_done_nxt = 1'b0;
               end
            end
            RX_ACK: if (scl_fall) sda_oe_nxt = 1'b0;
            TX: begin
               if (scl_fall) begin
                  if (bit_cnt == 3'd0) begin
                     sda_oe_nxt = 1'b0;
                  end else begin
                     shreg_nxt   = {shreg[6:0], 1'b0};
                     sda_oe_nxt  = ~shreg[6];
                     bit_cnt_nxt = bit_cnt + 3'd1;
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  if (!sda_f) begin
                     tx_req_nxt    = 1'b1;
                     byte_done_nxt = 1'b1;
                  end else begin
                     busy_nxt = 1'b0;
                  end
               end else if (scl_fall && byte_done) begin
                  byte_done_nxt = 1'b0;
                  shreg_nxt     = i_tx_data;
                  sda_oe_nxt    = ~i_tx_data[7];
                  bit_cnt_nxt   = 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
